mine_placer: RTL

- Populates the board mine map at the start of each game from the active difficulty setup: row/column count and mine count, taken from the low bits of game_setup_mem_t.
- Sits between the difficulty setup and the board logic.
- Places exactly the requested number of unique mines at pseudo-random coordinates, excluding one safe field (the first-click field), and streams each placement to board memory.
- Also exposes a registered read port for mine lookup during play.

---
 rtl/mine_placer_if.sv | 27 ++
 rtl/mine_placer.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/mine_placer_if.sv
// rtl/mine_placer_if.sv - control, write-stream and lookup signals of the mine placer
interface mine_placer_if;
  logic       start;
  logic [4:0] row_column_number;
  logic [7:0] mine_number;
  logic [3:0] safe_x;
  logic [3:0] safe_y;
  logic       busy;
  logic       done;
  logic       mine_wr_en;
  logic [3:0] mine_wr_x;
  logic [3:0] mine_wr_y;
  logic [7:0] mines_placed;
  logic [3:0] rd_x;
  logic [3:0] rd_y;
  logic       rd_mine;

  modport master (
    output start, row_column_number, mine_number, safe_x, safe_y, rd_x, rd_y,
    input  busy, done, mine_wr_en, mine_wr_x, mine_wr_y, mines_placed, rd_mine
  );

  modport slave (
    input  start, row_column_number, mine_number, safe_x, safe_y, rd_x, rd_y,
    output busy, done, mine_wr_en, mine_wr_x, mine_wr_y, mines_placed, rd_mine
  );
endinterface

// File: rtl/mine_placer.sv
// rtl/mine_placer.sv - places unique pseudo-random mines on the board, avoiding the first-click field
module mine_placer #(
  parameter int          MAX_DIM = 16,
  parameter logic [15:0] SEED    = 16'hACE1
) (
  input logic          clk,
  input logic          rst_n,
  mine_placer_if.slave bus
);

  localparam int          CELLS     = MAX_DIM * MAX_DIM;
  localparam int          IW        = $clog2(CELLS);
  localparam logic [15:0] SEED_EFF  = (SEED == 16'h0000) ? 16'h0001 : SEED;
  localparam logic [15:0] LFSR_MASK = 16'hB400;
  localparam logic [4:0]  N_MAX     = 5'(MAX_DIM);

  typedef enum logic [1:0] {IDLE, CLEAR, PLACE, FINISH} state_t;

  state_t           state;
  logic [15:0]      lfsr;
  logic [15:0]      lfsr_next;
  logic [CELLS-1:0] bitmap;
  logic [4:0]       n_q;
  logic [8:0]       target_q;
  logic [3:0]       safe_x_q;
  logic [3:0]       safe_y_q;

  logic             busy_q;
  logic             done_q;
  logic             wr_en_q;
  logic [3:0]       wr_x_q;
  logic [3:0]       wr_y_q;
  logic [7:0]       placed_q;
  logic             rd_mine_q;

  logic [4:0]       n_eff;
  logic [8:0]       n_sq;
  logic [8:0]       target_eff;
  logic [3:0]       cand_x;
  logic [3:0]       cand_y;
  logic [IW-1:0]    cand_idx;
  logic [IW-1:0]    rd_idx;
  logic             accept;
  logic             last_mine;
  logic             rd_hit;

  // Clamp dimension and mine count; one field always stays free for the first click.
  always_comb begin
    n_eff = (bus.row_column_number > N_MAX) ? N_MAX : bus.row_column_number;
    n_sq  = 9'(n_eff) * 9'(n_eff);
    if (n_sq == 9'd0) begin
      target_eff = 9'd0;
    end else if ({1'b0, bus.mine_number} < (n_sq - 9'd1)) begin
      target_eff = {1'b0, bus.mine_number};
    end else begin
      target_eff = n_sq - 9'd1;
    end
  end

  always_comb begin
    lfsr_next = lfsr[0] ? ((lfsr >> 1) ^ LFSR_MASK) : (lfsr >> 1);
    cand_x    = lfsr[3:0];
    cand_y    = lfsr[7:4];
    cand_idx  = IW'(int'(cand_y) * MAX_DIM + int'(cand_x));
    rd_idx    = IW'(int'(bus.rd_y) * MAX_DIM + int'(bus.rd_x));
    accept    = ({1'b0, cand_x} < n_q) && ({1'b0, cand_y} < n_q)
                && !((cand_x == safe_x_q) && (cand_y == safe_y_q))
                && !bitmap[cand_idx];
    last_mine = ((9'(placed_q) + 9'd1) == target_q);
    rd_hit    = ({1'b0, bus.rd_x} < n_q) && ({1'b0, bus.rd_y} < n_q) && bitmap[rd_idx];
  end

  // The LFSR free-runs in every state so the field depends on when start arrives.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      lfsr      <= SEED_EFF;
      bitmap    <= '0;
      n_q       <= 5'd0;
      target_q  <= 9'd0;
      safe_x_q  <= 4'd0;
      safe_y_q  <= 4'd0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      wr_en_q   <= 1'b0;
      wr_x_q    <= 4'd0;
      wr_y_q    <= 4'd0;
      placed_q  <= 8'd0;
      rd_mine_q <= 1'b0;
    end else begin
      lfsr      <= lfsr_next;
      done_q    <= 1'b0;
      wr_en_q   <= 1'b0;
      rd_mine_q <= rd_hit;
      case (state)
        IDLE: begin
          if (bus.start) begin
            n_q      <= n_eff;
            target_q <= target_eff;
            safe_x_q <= bus.safe_x;
            safe_y_q <= bus.safe_y;
            busy_q   <= 1'b1;
            state    <= CLEAR;
          end
        end
        CLEAR: begin
          bitmap   <= '0;
          placed_q <= 8'd0;
          if (target_q == 9'd0) begin
            busy_q <= 1'b0;
            done_q <= 1'b1;
            state  <= FINISH;
          end else begin
            state <= PLACE;
          end
        end
        PLACE: begin
          if (accept) begin
            bitmap[cand_idx] <= 1'b1;
            wr_en_q          <= 1'b1;
            wr_x_q           <= cand_x;
            wr_y_q           <= cand_y;
            placed_q         <= placed_q + 8'd1;
            if (last_mine) begin
              busy_q <= 1'b0;
              done_q <= 1'b1;
              state  <= FINISH;
            end
          end
        end
        FINISH: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy         = busy_q;
  assign bus.done         = done_q;
  assign bus.mine_wr_en   = wr_en_q;
  assign bus.mine_wr_x    = wr_x_q;
  assign bus.mine_wr_y    = wr_y_q;
  assign bus.mines_placed = placed_q;
  assign bus.rd_mine      = rd_mine_q;

endmodule
